// File: rtl/comma_aligner_rd_pkg.sv
// Shared constants, state encoding and ones-count helper for the comma aligner.
package comma_aligner_rd_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [3:0] ones_count(input logic [SYM_W-1:0] s);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < SYM_W; i++) begin
      cnt = cnt + {3'd0, s[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/comma_aligner_rd_sym_disparity_chk.sv
// Combinational running-disparity and code check for one 10-bit symbol.
module comma_aligner_rd_sym_disparity_chk
  import comma_aligner_rd_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  input  logic             rd_i,
  output logic             next_rd_o,
  output logic             code_err_o,
  output logic             disp_err_o
);

  logic [3:0] ones_s;

  assign ones_s = ones_count(sym_i);

  // Classify by ones count: 4 and 6 flip RD, 5 is neutral, anything else is illegal.
  always_comb begin
    next_rd_o  = rd_i;
    code_err_o = 1'b0;
    disp_err_o = 1'b0;
    case (ones_s)
      4'd4: begin
        next_rd_o  = 1'b0;
        disp_err_o = ~rd_i;
      end
      4'd5: begin
        next_rd_o  = rd_i;
      end
      4'd6: begin
        next_rd_o  = 1'b1;
        disp_err_o = rd_i;
      end
      default: begin
        code_err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/comma_aligner_rd.sv
// K28.5 comma aligner: finds the 10-bit boundary in a serial stream and emits symbols with RD.
// Build option: define COMMA_REALIGN_EN to let a misaligned comma realign while LOCKED.
module comma_aligner_rd
  import comma_aligner_rd_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int ERR_MAX  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [SYM_W-1:0] sym_out,
  output logic             sym_valid,
  output logic             rd_out,
  output logic             is_comma,
  output logic             code_err,
  output logic             disp_err,
  output logic             locked
);

  localparam logic [3:0] LOCK_CNT_C = 4'(LOCK_CNT);
  localparam logic [3:0] ERR_MAX_C  = 4'(ERR_MAX);

  state_e           state_q, state_d;
  logic [SYM_W-1:0] win_q, win_d, win_next_s;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic             rd_q, rd_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic             sym_valid_q, sym_valid_d;
  logic             rd_out_q, rd_out_d;
  logic             is_comma_q, is_comma_d;
  logic             code_err_q, code_err_d;
  logic             disp_err_q, disp_err_d;
  logic             locked_q, locked_d;

  logic match_n_s, match_p_s, match_s, aligned_s, realign_s, emit_s;
  logic chk_next_rd_s, chk_code_err_s, chk_disp_err_s;

  assign win_next_s = {win_q[SYM_W-2:0], bit_in};
  assign match_n_s  = (win_next_s == K28_5_RDN);
  assign match_p_s  = (win_next_s == K28_5_RDP);
  assign match_s    = match_n_s | match_p_s;
  assign aligned_s  = (bit_cnt_q == 4'd9);

`ifdef COMMA_REALIGN_EN
  assign realign_s = bit_valid & match_s & ((state_q == HUNT) | ~aligned_s);
`else
  assign realign_s = bit_valid & match_s &
                     ((state_q == HUNT) | ((state_q == VERIFY) & ~aligned_s));
`endif
  assign emit_s = bit_valid & (state_q != HUNT) & aligned_s & ~realign_s;

  comma_aligner_rd_sym_disparity_chk u_chk (
    .sym_i      (win_next_s),
    .rd_i       (rd_q),
    .next_rd_o  (chk_next_rd_s),
    .code_err_o (chk_code_err_s),
    .disp_err_o (chk_disp_err_s)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, window, counters and running disparity
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    err_cnt_d   = err_cnt_q;
    rd_d        = rd_q;
    if (bit_valid) begin
      win_d = win_next_s;
      if (state_q != HUNT) begin
        bit_cnt_d = aligned_s ? 4'd0 : (bit_cnt_q + 4'd1);
      end else begin
        bit_cnt_d = bit_cnt_q;
      end
    end else begin
      win_d = win_q;
    end
    if (realign_s) begin
      bit_cnt_d   = 4'd0;
      rd_d        = ~match_p_s;
      comma_cnt_d = 4'd1;
      err_cnt_d   = 4'd0;
      state_d     = VERIFY;
    end else if (emit_s) begin
      rd_d = chk_next_rd_s;
      case (state_q)
        VERIFY: begin
          if (chk_code_err_s) begin
            state_d     = HUNT;
            comma_cnt_d = 4'd0;
          end else if (match_s) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if ((comma_cnt_q + 4'd1) == LOCK_CNT_C) begin
              state_d   = LOCKED;
              err_cnt_d = 4'd0;
            end else begin
              state_d = VERIFY;
            end
          end else begin
            state_d = VERIFY;
          end
        end
        LOCKED: begin
          if (chk_code_err_s) begin
            if ((err_cnt_q + 4'd1) == ERR_MAX_C) begin
              state_d     = HUNT;
              err_cnt_d   = 4'd0;
              comma_cnt_d = 4'd0;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end else begin
            err_cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      rd_d = rd_q;
    end
  end

  // Registered output values; sym_out and rd_out hold between strobes
  always_comb begin
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    rd_out_d    = rd_out_q;
    is_comma_d  = 1'b0;
    code_err_d  = 1'b0;
    disp_err_d  = 1'b0;
    locked_d    = (state_d == LOCKED);
    if (realign_s) begin
      sym_d       = win_next_s;
      sym_valid_d = 1'b1;
      is_comma_d  = 1'b1;
      rd_out_d    = match_p_s;
    end else if (emit_s) begin
      sym_d       = win_next_s;
      sym_valid_d = 1'b1;
      rd_out_d    = rd_q;
      is_comma_d  = match_s;
      code_err_d  = chk_code_err_s;
      disp_err_d  = chk_disp_err_s;
    end else begin
      sym_valid_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q       <= '0;
      bit_cnt_q   <= 4'd0;
      comma_cnt_q <= 4'd0;
      err_cnt_q   <= 4'd0;
      rd_q        <= 1'b0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      rd_out_q    <= 1'b0;
      is_comma_q  <= 1'b0;
      code_err_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      win_q       <= win_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rd_q        <= rd_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      rd_out_q    <= rd_out_d;
      is_comma_q  <= is_comma_d;
      code_err_q  <= code_err_d;
      disp_err_q  <= disp_err_d;
      locked_q    <= locked_d;
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign rd_out    = rd_out_q;
  assign is_comma  = is_comma_q;
  assign code_err  = code_err_q;
  assign disp_err  = disp_err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_comma_aligner_rd.sv
// Directed bench for comma_aligner_rd: alignment, lock, disparity error, loss of lock, reset, gaps.
module tb_comma_aligner_rd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic [9:0] sym_out;
  logic       sym_valid, rd_out, is_comma, code_err, disp_err, locked;

  int checks = 0;
  int failures = 0;

  localparam logic [9:0] RDN  = 10'b0011111010;
  localparam logic [9:0] RDP  = 10'b1100000101;
  localparam logic [9:0] D215 = 10'b1010101010;
  localparam logic [9:0] DERR = 10'b1110001011;
  localparam logic [9:0] ZERO = 10'b0000000000;
  localparam int         NEV  = 11;

  logic        stream_q[$];
  logic [14:0] got_q[$];
  logic [14:0] exp_ev[NEV];

  comma_aligner_rd dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .sym_out   (sym_out),
    .sym_valid (sym_valid),
    .rd_out    (rd_out),
    .is_comma  (is_comma),
    .code_err  (code_err),
    .disp_err  (disp_err),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // Record every emitted symbol with its flags
  always @(negedge clk) begin
    if (sym_valid) got_q.push_back({sym_out, rd_out, is_comma, code_err, disp_err, locked});
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [14:0] ev(input logic [9:0] s, input logic rd, input logic cm,
                                     input logic ce, input logic de, input logic lk);
    return {s, rd, cm, ce, de, lk};
  endfunction

  task automatic push_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) stream_q.push_back(s[i]);
  endtask

  task automatic push_junk();
    for (int i = 0; i < 3; i++) stream_q.push_back(1'b1);
  endtask

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      int n;
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    bit_in    = b;
    bit_valid = 1'b1;
  endtask

  task automatic run_stream(input bit gaps, input string name);
    logic [14:0] g;
    got_q.delete();
    for (int i = 0; i < stream_q.size(); i++) begin
      send_bit(stream_q[i], gaps);
      if (i == 12) begin
        @(negedge clk);
        bit_valid = 1'b0;
        check_val({name, "_latency"}, {31'd0, sym_valid}, 32'd1);
        @(negedge clk);
        check_val({name, "_strobe"}, {31'd0, sym_valid}, 32'd0);
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_val({name, "_ev_count"}, got_q.size(), NEV);
    for (int i = 0; i < NEV; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 15'h7fff;
      check_val($sformatf("%s_ev%0d", name, i), {17'd0, g}, {17'd0, exp_ev[i]});
    end
  endtask

  initial begin
    push_junk(); push_sym(RDN); push_sym(D215); push_sym(RDP); push_sym(D215);
    push_sym(RDN); push_sym(DERR);
    for (int i = 0; i < 4; i++) push_sym(ZERO);
    push_junk(); push_sym(RDN);

    exp_ev[0]  = ev(RDN,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_ev[1]  = ev(D215, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ev[2]  = ev(RDP,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_ev[3]  = ev(D215, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_ev[4]  = ev(RDN,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    exp_ev[5]  = ev(DERR, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    exp_ev[6]  = ev(ZERO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_ev[7]  = ev(ZERO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_ev[8]  = ev(ZERO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    exp_ev[9]  = ev(ZERO, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_ev[10] = ev(RDN,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_val("reset_outs", {16'd0, sym_out, sym_valid, rd_out, is_comma, code_err, disp_err, locked}, 32'd0);
    rst = 1'b1;

    run_stream(1'b0, "nogap");

    // Reset in the middle of a symbol, then confirm HUNT emits nothing without a comma
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    @(negedge clk);
    rst       = 1'b0;
    bit_valid = 1'b0;
    #1;
    check_val("midreset_outs", {16'd0, sym_out, sym_valid, rd_out, is_comma, code_err, disp_err, locked}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    got_q.delete();
    for (int i = 0; i < 20; i++) send_bit(i[0] ? 1'b0 : 1'b1, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("hunt_no_sym", got_q.size(), 32'd0);

    run_stream(1'b1, "gaps");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
